// File: rtl/recfg_adder_sched.sv
// Round-robin scheduler sharing one 8-bit reconfigurable add/sub datapath between
// N_REQ requesters; inserts a settle interval whenever the datapath mode changes.
module recfg_adder_sched #(
    parameter int N_REQ      = 4,
    parameter int CFG_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [2*N_REQ-1:0]   req_mode,
    input  logic [8*N_REQ-1:0]   req_a1,
    input  logic [8*N_REQ-1:0]   req_a2,
    input  logic [8*N_REQ-1:0]   req_b,
    output logic [7:0]           dp_a1,
    output logic [7:0]           dp_a2,
    output logic [7:0]           dp_b,
    output logic                 dp_s0,
    output logic                 dp_s1,
    input  logic [8:0]           dp_y,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [2:0]           rsp_id,
    output logic [8:0]           rsp_y,
    output logic                 busy,
    output logic [15:0]          op_count
);

    // state | meaning
    // IDLE  | nothing in flight, arbitrating
    // CFG   | mode settling, cfg_cnt counting down
    // EXEC  | datapath evaluating, result captured on exit
    // RESP  | result held until rsp_ready; re-arbitrates on that cycle
    typedef enum logic [1:0] {IDLE, CFG, EXEC, RESP} state_t;

    state_t      state;
    logic [1:0]  cur_mode;
    logic [3:0]  cfg_cnt;
    logic [2:0]  last_grant;
    logic [2:0]  owner;

    logic        arb_en;
    logic        grant_found;
    logic [2:0]  grant;
    logic [3:0]  idx;
    logic        handshake;
    logic [7:0]  valid_pad;
    logic [7:0]  ready_pad;
    logic [15:0] mode_pad;
    logic [63:0] a1_pad;
    logic [63:0] a2_pad;
    logic [63:0] b_pad;
    logic [1:0]  grant_mode;

    // Requester vectors padded to the 8-requester maximum so a 3-bit grant indexes them directly.
    assign valid_pad  = 8'(req_valid);
    assign mode_pad   = 16'(req_mode);
    assign a1_pad     = 64'(req_a1);
    assign a2_pad     = 64'(req_a2);
    assign b_pad      = 64'(req_b);
    assign grant_mode = mode_pad[{grant, 1'b0} +: 2];

    assign arb_en    = rst_n && ((state == IDLE) || ((state == RESP) && rsp_ready));
    assign handshake = arb_en && grant_found;
    assign busy      = (state != IDLE);

    always_comb begin
        grant_found = 1'b0;
        grant       = '0;
        idx         = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = {1'b0, last_grant} + 4'd1 + 4'(k);
            if (idx >= 4'(N_REQ)) idx = idx - 4'(N_REQ);
            if (!grant_found && valid_pad[idx[2:0]]) begin
                grant_found = 1'b1;
                grant       = idx[2:0];
            end
        end
    end

    always_comb begin
        ready_pad = '0;
        if (handshake) ready_pad[grant] = 1'b1;
        req_ready = ready_pad[N_REQ-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cur_mode   <= 2'b00;
            cfg_cnt    <= '0;
            last_grant <= 3'(N_REQ-1);
            owner      <= '0;
            dp_a1      <= '0;
            dp_a2      <= '0;
            dp_b       <= '0;
            dp_s0      <= 1'b0;
            dp_s1      <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_y      <= '0;
            op_count   <= '0;
        end else begin
            case (state)
                IDLE, RESP: begin
                    if ((state == RESP) && rsp_ready) begin
                        rsp_valid <= 1'b0;
                        op_count  <= op_count + 16'd1;
                        state     <= IDLE;
                    end
                    if (handshake) begin
                        dp_a1          <= a1_pad[{grant, 3'b000} +: 8];
                        dp_a2          <= a2_pad[{grant, 3'b000} +: 8];
                        dp_b           <= b_pad[{grant, 3'b000} +: 8];
                        {dp_s0, dp_s1} <= grant_mode;
                        owner          <= grant;
                        last_grant     <= grant;
                        cur_mode       <= grant_mode;
                        if (grant_mode != cur_mode) begin
                            state   <= CFG;
                            cfg_cnt <= 4'(CFG_CYCLES-1);
                        end else begin
                            state <= EXEC;
                        end
                    end
                end
                CFG: begin
                    if (cfg_cnt == 4'd0) state <= EXEC;
                    else                 cfg_cnt <= cfg_cnt - 4'd1;
                end
                EXEC: begin
                    rsp_y     <= dp_y;
                    rsp_id    <= owner;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_recfg_adder_sched.sv
// Directed self-checking bench for recfg_adder_sched with a behavioural model of the
// external add/sub datapath.
module tb_recfg_adder_sched;
    localparam int N = 4;
    localparam int CC = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] req_valid;
    logic [N-1:0] req_ready;
    logic [2*N-1:0] req_mode;
    logic [8*N-1:0] req_a1, req_a2, req_b;
    logic [7:0]   dp_a1, dp_a2, dp_b;
    logic         dp_s0, dp_s1;
    logic [8:0]   dp_y;
    logic         rsp_valid, rsp_ready;
    logic [2:0]   rsp_id;
    logic [8:0]   rsp_y;
    logic         busy;
    logic [15:0]  op_count;

    int total = 0;
    int bad = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    recfg_adder_sched #(.N_REQ(N), .CFG_CYCLES(CC)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
        .req_a1(req_a1), .req_a2(req_a2), .req_b(req_b),
        .dp_a1(dp_a1), .dp_a2(dp_a2), .dp_b(dp_b), .dp_s0(dp_s0), .dp_s1(dp_s1),
        .dp_y(dp_y), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_y(rsp_y), .busy(busy), .op_count(op_count)
    );

    // Datapath model: 00 a1+b, 01 a1+a2, 10 a2+b, 11 a1-b
    always_comb begin
        case ({dp_s0, dp_s1})
            2'b00:   dp_y = {1'b0, dp_a1} + {1'b0, dp_b};
            2'b01:   dp_y = {1'b0, dp_a1} + {1'b0, dp_a2};
            2'b10:   dp_y = {1'b0, dp_a2} + {1'b0, dp_b};
            default: dp_y = {1'b0, dp_a1} - {1'b0, dp_b};
        endcase
    end

    task automatic set_req(input int id, input logic [1:0] m, input logic [7:0] x1, x2, xb);
        req_mode[2*id +: 2] = m;
        req_a1[8*id +: 8]   = x1;
        req_a2[8*id +: 8]   = x2;
        req_b[8*id +: 8]    = xb;
    endtask

    // Issue one op from requester id (rsp_ready assumed high); lat counts edges from the grant cycle.
    task automatic do_op(input int id, input logic [1:0] m, input logic [7:0] x1, x2, xb,
                         output int lat, output logic [8:0] y, output logic [2:0] rid,
                         output bit stable);
        logic [25:0] dpv0;
        lat = -1; y = 'x; rid = 'x; stable = 1'b1; dpv0 = '0;
        set_req(id, m, x1, x2, xb);
        req_valid[id] = 1'b1;
        #1;
        for (int i = 0; i < 20 && !req_ready[id]; i++) @(negedge clk);
        if (!req_ready[id]) begin
            req_valid[id] = 1'b0;
            return;
        end
        for (int e = 1; e <= 20; e++) begin
            @(negedge clk);
            if (e == 1) begin
                req_valid[id] = 1'b0;
                dpv0 = {dp_a1, dp_a2, dp_b, dp_s0, dp_s1};
            end else if ({dp_a1, dp_a2, dp_b, dp_s0, dp_s1} !== dpv0) begin
                stable = 1'b0;
            end
            if (rsp_valid) begin
                lat = e; y = rsp_y; rid = rsp_id;
                break;
            end
        end
        if (lat > 0) exp_cnt++;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        req_valid = 4'b0001;
        repeat (2) @(negedge clk);
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_req_ready got=%b want=0000", req_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
        total++; if ({rsp_y, rsp_id} !== 12'h000) begin bad++; $display("FAIL reset_rsp got=%h want=000", {rsp_y, rsp_id}); end
        total++; if (op_count !== 16'h0000) begin bad++; $display("FAIL reset_op_count got=%h want=0000", op_count); end
        total++; if ({dp_a1, dp_a2, dp_b, dp_s0, dp_s1} !== 26'h0) begin bad++; $display("FAIL reset_dp got=%h want=0", {dp_a1, dp_a2, dp_b, dp_s0, dp_s1}); end
        req_valid = '0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op;
        bit seen;
        seen = 1'b0;
        rsp_ready = 1'b1;
        set_req(0, 2'b01, 8'h11, 8'h22, 8'h33);
        req_valid[0] = 1'b1;
        #1;
        for (int i = 0; i < 20 && !req_ready[0]; i++) @(negedge clk);
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL midrst_grant got=%b want=0001", req_ready); end
        @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL midrst_busy_cfg got=%b want=1", busy); end
        total++; if ({dp_s0, dp_s1} !== 2'b01) begin bad++; $display("FAIL midrst_dp_mode got=%b want=01", {dp_s0, dp_s1}); end
        rst_n = 1'b0;
        req_valid[0] = 1'b1;
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", busy); end
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL midrst_req_ready got=%b want=0000", req_ready); end
        total++; if ({dp_a1, dp_a2, dp_b, dp_s0, dp_s1} !== 26'h0) begin bad++; $display("FAIL midrst_dp got=%h want=0", {dp_a1, dp_a2, dp_b, dp_s0, dp_s1}); end
        req_valid[0] = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (rsp_valid) seen = 1'b1;
            @(negedge clk);
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL midrst_no_rsp got=%b want=0", seen); end
        total++; if (op_count !== 16'h0000) begin bad++; $display("FAIL midrst_op_count got=%h want=0000", op_count); end
    endtask

    task automatic test_single_op;
        int lat; logic [8:0] y; logic [2:0] rid; bit st;
        rsp_ready = 1'b1;
        do_op(0, 2'b00, 8'h80, 8'h00, 8'h90, lat, y, rid, st);
        total++; if (lat !== 2) begin bad++; $display("FAIL single_latency got=%0d want=2", lat); end
        total++; if (y !== 9'h110) begin bad++; $display("FAIL single_rsp_y got=%h want=110", y); end
        total++; if (rid !== 3'd0) begin bad++; $display("FAIL single_rsp_id got=%0d want=0", rid); end
        total++; if (op_count !== 16'd1) begin bad++; $display("FAIL single_op_count got=%0d want=1", op_count); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_idle got=%b want=0", busy); end
    endtask

    task automatic test_mode_change;
        int lat; logic [8:0] y; logic [2:0] rid; bit st;
        do_op(1, 2'b00, 8'h12, 8'h00, 8'h34, lat, y, rid, st);
        total++; if (lat !== 2 || y !== 9'h046 || rid !== 3'd1) begin bad++; $display("FAIL mode_same got lat=%0d y=%h id=%0d want lat=2 y=046 id=1", lat, y, rid); end
        do_op(2, 2'b10, 8'h00, 8'h7F, 8'h01, lat, y, rid, st);
        total++; if (lat !== 2 + CC) begin bad++; $display("FAIL mode_change_latency got=%0d want=%0d", lat, 2 + CC); end
        total++; if (y !== 9'h080 || rid !== 3'd2) begin bad++; $display("FAIL mode_change_rsp got y=%h id=%0d want y=080 id=2", y, rid); end
        total++; if (st !== 1'b1) begin bad++; $display("FAIL mode_change_dp_stable got=%b want=1", st); end
        do_op(3, 2'b10, 8'h00, 8'hFF, 8'hFF, lat, y, rid, st);
        total++; if (lat !== 2 || y !== 9'h1FE || rid !== 3'd3) begin bad++; $display("FAIL mode_keep got lat=%0d y=%h id=%0d want lat=2 y=1fe id=3", lat, y, rid); end
        total++; if (op_count !== 16'(exp_cnt)) begin bad++; $display("FAIL mode_op_count got=%0d want=%0d", op_count, exp_cnt); end
    endtask

    task automatic test_round_robin;
        int gq[5]; int rq[5]; int rc[5]; logic [8:0] ry[5];
        int ng, nr, g;
        ng = 0; nr = 0;
        for (int i = 0; i < N; i++) set_req(i, 2'b10, 8'(i), 8'(16 * i + 1), 8'h20);
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        #1;
        for (int s = 0; s <= 10; s++) begin
            if (req_ready != 0 && ng < 5) begin
                total++; if ($countones(req_ready) != 1) begin bad++; $display("FAIL rr_onehot got=%b want=one-hot", req_ready); end
                g = 0;
                for (int b = 0; b < N; b++) if (req_ready[b]) g = b;
                gq[ng] = g; ng++;
            end
            if (rsp_valid && nr < 5) begin
                rq[nr] = int'(rsp_id); ry[nr] = rsp_y; rc[nr] = s; nr++;
            end
            if (s == 10) req_valid = '0;
            else @(negedge clk);
        end
        @(negedge clk);
        exp_cnt += nr;
        total++; if (ng !== 5 || nr !== 5) begin bad++; $display("FAIL rr_counts got grants=%0d rsps=%0d want 5 5", ng, nr); end
        for (int k = 0; k < ng; k++) begin
            total++; if (gq[k] !== k % 4) begin bad++; $display("FAIL rr_grant_%0d got=%0d want=%0d", k, gq[k], k % 4); end
        end
        for (int k = 0; k < nr; k++) begin
            total++; if (rq[k] !== k % 4 || ry[k] !== 9'(33 + 16 * (k % 4)) || rc[k] !== 2 + 2 * k) begin
                bad++; $display("FAIL rr_rsp_%0d got id=%0d y=%h cyc=%0d want id=%0d y=%h cyc=%0d",
                                k, rq[k], ry[k], rc[k], k % 4, 9'(33 + 16 * (k % 4)), 2 + 2 * k);
            end
        end
        total++; if (op_count !== 16'(exp_cnt)) begin bad++; $display("FAIL rr_op_count got=%0d want=%0d", op_count, exp_cnt); end
    endtask

    task automatic test_backpressure;
        bit held;
        held = 1'b1;
        rsp_ready = 1'b0;
        set_req(3, 2'b10, 8'h00, 8'h05, 8'h06);
        req_valid[3] = 1'b1;
        #1;
        for (int i = 0; i < 20 && !req_ready[3]; i++) @(negedge clk);
        total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL bp_grant3 got=%b want=1000", req_ready); end
        @(negedge clk);
        req_valid[3] = 1'b0;
        @(negedge clk);
        set_req(1, 2'b10, 8'h00, 8'h40, 8'h02);
        req_valid[1] = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            if (rsp_valid !== 1'b1 || rsp_y !== 9'h00B || rsp_id !== 3'd3 || req_ready !== 4'b0000) held = 1'b0;
            @(negedge clk);
        end
        total++; if (held !== 1'b1) begin bad++; $display("FAIL bp_hold got=%b want=1 (y=%h id=%0d ready=%b)", held, rsp_y, rsp_id, req_ready); end
        rsp_ready = 1'b1;
        #1;
        total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL bp_release_grant got=%b want=0010", req_ready); end
        @(negedge clk);
        req_valid[1] = 1'b0;
        exp_cnt++;
        total++; if (op_count !== 16'(exp_cnt)) begin bad++; $display("FAIL bp_accept_count got=%0d want=%0d", op_count, exp_cnt); end
        @(negedge clk);
        total++; if (rsp_valid !== 1'b1 || rsp_id !== 3'd1 || rsp_y !== 9'h042) begin bad++; $display("FAIL bp_req1_rsp got v=%b id=%0d y=%h want v=1 id=1 y=042", rsp_valid, rsp_id, rsp_y); end
        @(negedge clk);
        exp_cnt++;
        total++; if (op_count !== 16'(exp_cnt)) begin bad++; $display("FAIL bp_final_count got=%0d want=%0d", op_count, exp_cnt); end
    endtask

    task automatic test_wrap;
        int lat; logic [8:0] y; logic [2:0] rid; bit st;
        force dut.op_count = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.op_count;
        @(negedge clk);
        do_op(2, 2'b10, 8'h00, 8'h01, 8'h01, lat, y, rid, st);
        total++; if (lat !== 2 || y !== 9'h002) begin bad++; $display("FAIL wrap_op got lat=%0d y=%h want lat=2 y=002", lat, y); end
        total++; if (op_count !== 16'h0000) begin bad++; $display("FAIL wrap_op_count got=%h want=0000", op_count); end
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = '0;
        req_mode = '0;
        req_a1 = '0;
        req_a2 = '0;
        req_b = '0;
        rsp_ready = 1'b0;
        @(negedge clk);
        test_reset;
        test_reset_mid_op;
        test_single_op;
        test_mode_change;
        test_round_robin;
        test_backpressure;
        test_wrap;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
